instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch stage: holds the PC and issues word requests to instruction memory.
//  Buffers returned words with their PCs and hands them to decode (imm_gen/control) over valid/ready.
//  Accepts branch/jump redirects from execute and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC of the first fetch after reset
//  FIFO_DEPTH   2              instr/PC buffer entries (power of 2, >=2)
//  MAX_OUTST    2              max imem requests granted but not yet returned
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  redirect_valid in   1   execute: taken branch/jump this cycle
//  redirect_pc    in   32  new fetch target
//  imem_req       out  1   memory request
//  imem_addr      out  32  word address (bits[1:0]=0)
//  imem_gnt       in   1   request accepted this cycle
//  imem_rvalid    in   1   read data valid; responses return in order
//  imem_rdata     in   32  instruction word
//  if_valid       out  1   if_instr/if_pc valid to decode
//  if_ready       in   1   decode accepts this cycle
//  if_instr       out  32  instruction to decode
//  if_pc          out  32  PC of if_instr
//  misalign_err   out  1   misaligned redirect (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=IDLE.
//   imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, misalign_err=0.
//  FSM states: IDLE -> RUN (first cycle after reset release); RUN -> HALT on misalign only; HALT exits by reset only.
//  Issue: in RUN, imem_req=1 when outstanding + fifo_count < FIFO_DEPTH and outstanding < MAX_OUTST.
//   While req=1 && gnt=0, imem_addr and req hold stable.
//   On gnt: outstanding++, fetch_pc+=4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
//  Response: on rvalid with discard=0, push {imem_rdata, PC of that request}; outstanding--.
//   Request PCs are held in a MAX_OUTST-entry PC queue.
//   With discard>0, drop the word and decrement discard.
//  Latency: gnt in cycle N, rvalid in N+1 -> if_valid in N+2 (FIFO registered, no bypass).
//  Handshake: if_valid && if_ready pops the head.
//   if_instr/if_pc stay stable while if_valid && !if_ready.
//   if_instr=NOP whenever if_valid=0.
//  Redirect (redirect_valid=1, highest priority):
//   FIFO cleared the same edge (pop ignored).
//   discard = outstanding + (imem_gnt ? 1:0) - (imem_rvalid ? 1:0).
//   fetch_pc=redirect_pc; new address presented the next cycle.
//   if_valid=0 the cycle after the redirect.
//  Request pending without gnt at redirect: req drops for one cycle; no phantom count.
//  Simultaneous push and pop on a full FIFO is legal; count is unchanged.
//  Push when full cannot occur (issue credit rule); a bench assertion flags it.
//  rvalid with outstanding=0 and discard=0 is a protocol error, ignored.
// CONFIGURATION
//  Macro MISALIGN_CHECK_EN:
//   Defined: redirect_pc[1:0]!=0 -> misalign_err=1 for one cycle (next cycle), state=HALT.
//    In HALT: imem_req=0, FIFO flushed, if_valid=0.
//   Undefined: redirect_pc[1:0] forced to 2'b00, misalign_err tied 0, HALT unreachable.
// STRUCTURE
//  riscv_pkg: NOP_INSTR=32'h0000_0013, opcode localparams (shared with imm_gen/control),
//   fetch state enum {IDLE,RUN,HALT}.
//  Sub-module fetch_fifo: synchronous FIFO, WIDTH=64 (instr+pc), DEPTH=FIFO_DEPTH, flush input,
//   count output.
// TESTING
//  1 Reset release, gnt=1 always, rvalid 1 cycle later, ready=1
//     -> addrs 0,4,8...; if_pc 0 at cycle 3, then one instr/cycle.
//  2 ready=0 for 5 cycles -> exactly FIFO_DEPTH words buffered, req=0, if_instr stable;
//     ready=1 -> in-order drain.
//  3 gnt delayed 3 cycles -> imem_addr constant during wait; no duplicate or lost PC.
//  4 Redirect to 32'h100 with 2 outstanding -> both stale words dropped; next if_pc=32'h100.
//  5 Redirect same cycle as pop, gnt and rvalid -> stale-free output, discard count correct.
//  6 MISALIGN_CHECK_EN, redirect_pc=32'h102 -> misalign_err pulse, req=0 until rst;
//     without macro -> fetch from 32'h100.
//  PC wrap: start RESET_PC=32'hFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   NOP_INSTR      : canonical NOP (addi x0, x0, 0), presented by fetch when idle
//   OPC_*          : major opcodes, shared with imm_gen / control
//   fetch_state_e  : instruction-fetch sequencer states
//   fetch_entry_t  : one buffered fetch result (instruction word + its PC)
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched {instr, pc} pairs for decode.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write one entry (ignored when full unless a pop happens too)
//   pop      : remove the head entry (ignored when empty)
//   flush    : empty the FIFO; wins over push and pop
//   dout     : head entry (meaningful only while count != 0)
//   count    : number of valid entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; count gates every read,
    // so stale contents are never observed and the array maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction
// memory, buffers returned words with their PCs and hands them to decode.
//   redirect_valid/redirect_pc : taken branch/jump from execute
//   imem_req/addr/gnt          : request channel (addr held while req && !gnt)
//   imem_rvalid/rdata          : in-order response channel
//   if_valid/ready/instr/pc    : decode handshake; if_instr is NOP when !if_valid
//   misalign_err               : one-cycle pulse on a misaligned redirect
// Build option MISALIGN_CHECK_EN: when defined, a redirect with
// redirect_pc[1:0] != 0 pulses misalign_err and parks the stage in HALT until
// reset; when undefined, redirect_pc[1:0] is ignored and HALT is unreachable.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err
);

    localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    fetch_state_e state, state_next;
    logic [31:0]  fetch_pc;
    logic [CW-1:0] outstanding, outstanding_next, discard, fifo_count;
    logic [31:0]  pcq [MAX_OUTST];   // PCs of granted, not-yet-returned requests
    logic [PW-1:0] pcq_wr, pcq_rd;
    logic         redirect_q;
    logic         redir_take, redir_misaligned, gnt_ok, rsp_ok;
    logic         fifo_push, fifo_pop, fifo_flush;
    logic [31:0]  redir_target;
    fetch_entry_t fifo_din, fifo_dout;

    assign redir_take = redirect_valid && (state != HALT);

`ifdef MISALIGN_CHECK_EN
    assign redir_misaligned = redir_take && (redirect_pc[1:0] != 2'b00);
    assign redir_target     = redirect_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= redir_misaligned;
    end
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs   = ^redirect_pc[1:0];
    assign redir_misaligned = 1'b0;
    assign redir_target     = {redirect_pc[31:2], 2'b00};
    assign misalign_err     = 1'b0;
`endif

    assign gnt_ok = imem_req && imem_gnt;
    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_ok = imem_rvalid && (outstanding != '0);

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            IDLE: state_next = RUN;
            // Credit rule: in-flight plus buffered words never exceed the FIFO,
            // so a response always has a slot. The cycle after a redirect is
            // skipped so the new target is presented cleanly.
            RUN:  imem_req = !redirect_q
                             && ((outstanding + fifo_count) < CW'(FIFO_DEPTH))
                             && (outstanding < CW'(MAX_OUTST));
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
        if (redir_misaligned) state_next = HALT;
    end

    always_comb begin
        outstanding_next = outstanding;
        if (gnt_ok && !rsp_ok)      outstanding_next = outstanding + CW'(1);
        else if (!gnt_ok && rsp_ok) outstanding_next = outstanding - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            redirect_q  <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            redirect_q  <= redir_take;

            if (redir_take)  fetch_pc <= redir_target;
            else if (gnt_ok) fetch_pc <= fetch_pc + 32'd4;

            // Everything still in flight after this edge belongs to the old path.
            if (redir_take)                   discard <= outstanding_next;
            else if (rsp_ok && discard != '0) discard <= discard - CW'(1);

            if (gnt_ok) pcq_wr <= (pcq_wr == PW'(MAX_OUTST - 1)) ? '0 : pcq_wr + PW'(1);
            if (rsp_ok) pcq_rd <= (pcq_rd == PW'(MAX_OUTST - 1)) ? '0 : pcq_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_ok) pcq[pcq_wr] <= fetch_pc;
    end

    assign fifo_push  = rsp_ok && (discard == '0) && !redir_take;
    assign fifo_pop   = if_valid && if_ready && !redir_take;
    assign fifo_flush = redir_take || (state == HALT);
    assign fifo_din   = '{instr: imem_rdata, pc: pcq[pcq_rd]};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign imem_addr = fetch_pc;
    assign if_valid  = (fifo_count != '0);
    assign if_instr  = if_valid ? fifo_dout.instr : NOP_INSTR;
    assign if_pc     = if_valid ? fifo_dout.pc : RESET_PC;

endmodule
